// File: rtl/spi_word_receiver.sv
// spi_word_receiver: recovers addressed 16-bit words from a serial stream and queues them in a FIFO.
//
// Ports:
//   clk           sole clock; serial inputs are synchronous to it
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush of FIFO, shift register and pending write; counters kept
//   rx_data       serial data, MSB first (3 address bits then 16 data bits)
//   rx_load       high during the last (19th) bit of a frame
//   data          word at the FIFO head (don't-care while valid is low)
//   valid         data holds a word
//   ready         downstream accepts data this cycle
//   stop          backpressure to the transmitter, with hysteresis on fill level
//   ovf           sticky: an accepted word was lost to a full FIFO
//   addr_err_cnt  frames dropped for address mismatch, saturating at 255
//   state_mon     {stop, valid}
module spi_word_receiver #(
  parameter logic [2:0] MY_ADDR = 3'h1,
  parameter int DEPTH = 16,
  parameter int STOP_HI = 12,
  parameter int STOP_LO = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        rx_data,
  input  logic        rx_load,
  output logic [15:0] data,
  output logic        valid,
  input  logic        ready,
  output logic        stop,
  output logic        ovf,
  output logic [7:0]  addr_err_cnt,
  output logic [1:0]  state_mon
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] HI = (AW + 1)'(STOP_HI);
  localparam logic [AW:0] LO = (AW + 1)'(STOP_LO);
  typedef enum logic {RUN, HOLD} state_t;
  // Only the 18 most recent bits are kept; the 19th comes straight from rx_data on the load cycle.
  logic [17:0] sr;
  logic [18:0] frame;
  logic        hit;
  logic        wr_pend;
  logic        bad_pend;
  logic [15:0] wr_word;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0] fill;
  logic        rd;
  logic        wr;
  state_t      state;
  state_t      nxt;
  always_comb begin
    frame = {sr, rx_data};
    hit = frame[18:16] == MY_ADDR;
    valid = fill != '0;
    data = mem[rptr];
    rd = valid & ready;
    // A full FIFO still takes a write when a read frees the head slot on the same edge.
    wr = wr_pend & ((fill != FULL) | rd);
    nxt = (state == RUN) ? ((fill >= HI) ? HOLD : RUN) : ((fill <= LO) ? RUN : HOLD);
    stop = state == HOLD;
    state_mon = {stop, valid};
  end
  // Capture stage: decisions made on the load edge take effect one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      wr_pend <= 1'b0;
      bad_pend <= 1'b0;
      wr_word <= '0;
      addr_err_cnt <= '0;
      ovf <= 1'b0;
    end else begin
      sr <= clr ? '0 : frame[17:0];
      wr_pend <= rx_load & hit & ~clr;
      bad_pend <= rx_load & ~hit;
      wr_word <= frame[15:0];
      if (bad_pend && addr_err_cnt != 8'hFF)
        addr_err_cnt <= addr_err_cnt + 8'd1;
      if (wr_pend && !clr && !wr)
        ovf <= 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      fill <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wr_word;
        wptr <= wptr + 1'b1;
      end
      if (rd)
        rptr <= rptr + 1'b1;
      if (wr && !rd)
        fill <= fill + 1'b1;
      else if (rd && !wr)
        fill <= fill - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= HOLD;
    else
      state <= nxt;
  end
endmodule

// File: tb/tb_spi_word_receiver.sv
// tb_spi_word_receiver: directed self-checking bench for spi_word_receiver.
module tb_spi_word_receiver;
  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        rx_data;
  logic        rx_load;
  logic [15:0] data;
  logic        valid;
  logic        ready;
  logic        stop;
  logic        ovf;
  logic [7:0]  addr_err_cnt;
  logic [1:0]  state_mon;
  int n_cmp = 0;
  int n_bad = 0;
  spi_word_receiver dut (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .rx_data(rx_data),
    .rx_load(rx_load),
    .data(data),
    .valid(valid),
    .ready(ready),
    .stop(stop),
    .ovf(ovf),
    .addr_err_cnt(addr_err_cnt),
    .state_mon(state_mon)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_load = 1'b0;
      rx_data = 1'b0;
    end
  endtask
  // Leaves the last bit (with rx_load high) in front of the next rising edge.
  task automatic send_frame(input logic [2:0] a, input logic [15:0] w);
    logic [18:0] f;
    f = {a, w};
    for (int i = 18; i >= 0; i--) begin
      @(negedge clk);
      rx_data = f[i];
      rx_load = (i == 0);
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask
  initial begin
    rst_n = 1'b0;
    clr = 1'b0;
    rx_data = 1'b0;
    rx_load = 1'b0;
    ready = 1'b0;
    step(2);
    chk("rst_data", data, 16'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_stop", stop, 1'b1);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_cnt", addr_err_cnt, 8'd0);
    rst_n = 1'b1;
    step(1);
    chk("run_after_rst", stop, 1'b0);
    send_frame(3'h1, 16'hA5C3);
    step(1);
    chk("lat_not_yet", valid, 1'b0);
    step(1);
    chk("t1_valid", valid, 1'b1);
    chk("t1_data", data, 16'hA5C3);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("t1_drained", state_mon, 2'b00);
    send_frame(3'h3, 16'h1234);
    step(2);
    chk("t2_valid", valid, 1'b0);
    chk("t2_cnt1", addr_err_cnt, 8'd1);
    for (int i = 0; i < 300; i++)
      send_frame(3'h3, 16'(i));
    step(2);
    chk("t2_sat", addr_err_cnt, 8'd255);
    for (int i = 0; i < 12; i++)
      send_frame(3'h1, 16'(i));
    step(2);
    chk("t3_stop_pre", stop, 1'b0);
    step(1);
    chk("t3_stop_on", stop, 1'b1);
    for (int i = 12; i < 16; i++)
      send_frame(3'h1, 16'(i));
    step(2);
    chk("t3_ovf_pre", ovf, 1'b0);
    chk("t3_head", data, 16'h0);
    send_frame(3'h1, 16'h0010);
    step(2);
    chk("t3_ovf", ovf, 1'b1);
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t3_v%0d", k), valid, 1'b1);
      chk($sformatf("t3_d%0d", k), data, 16'(k));
      chk($sformatf("t3_s%0d", k), stop, (k < 9) ? 1'b1 : 1'b0);
      step(1);
    end
    ready = 1'b0;
    chk("t3_empty", valid, 1'b0);
    chk("t3_cnt_kept", addr_err_cnt, 8'd255);
    do_reset;
    for (int i = 0; i < 16; i++)
      send_frame(3'h1, 16'h0100 + 16'(i));
    send_frame(3'h1, 16'hBEEF);
    step(1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("t4_ovf", ovf, 1'b0);
    ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t4_v%0d", k), valid, 1'b1);
      chk($sformatf("t4_d%0d", k), data, (k < 15) ? 16'h0101 + 16'(k) : 16'hBEEF);
      step(1);
    end
    ready = 1'b0;
    chk("t4_empty", valid, 1'b0);
    send_frame(3'h5, 16'h7777);
    step(2);
    chk("t5_cnt_pre", addr_err_cnt, 8'd1);
    for (int i = 0; i < 5; i++)
      send_frame(3'h1, 16'h0050 + 16'(i));
    step(2);
    chk("t5_fill_v", valid, 1'b1);
    chk("t5_fill_d", data, 16'h0050);
    send_frame(3'h1, 16'h0055);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t5_clr_v", valid, 1'b0);
    step(1);
    chk("t5_drop_v", valid, 1'b0);
    chk("t5_cnt", addr_err_cnt, 8'd1);
    chk("t5_ovf", ovf, 1'b0);
    send_frame(3'h1, 16'h0066);
    step(2);
    chk("t5_next_v", valid, 1'b1);
    chk("t5_next_d", data, 16'h0066);
    begin
      logic [18:0] f;
      f = {3'h1, 16'hDEAD};
      for (int i = 18; i >= 9; i--) begin
        @(negedge clk);
        rx_data = f[i];
        rx_load = 1'b0;
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_data", data, 16'h0);
    chk("t6_mon", state_mon, 2'b10);
    chk("t6_cnt", addr_err_cnt, 8'd0);
    chk("t6_ovf", ovf, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t6_run", stop, 1'b0);
    send_frame(3'h1, 16'h9F3E);
    step(2);
    chk("t6_v", valid, 1'b1);
    chk("t6_d", data, 16'h9F3E);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/spi_word_receiver.md
# spi_word_receiver

Receive-side counterpart of the SPI output stage. Recovers 16-bit words from the serial stream (TX_DATA/TX_LOAD pair of the far-end serializer, addressed frames of 3 address bits + 16 data bits), filters by address, buffers accepted words in an internal FIFO and presents them downstream with a VALID/READY handshake. Drives STOP with hysteresis; STOP is routed to the transmitter's RX_STOP input to throttle it before the FIFO overflows.

## Interface

Parameters:
- MY_ADDR, 3'h1, address field a frame must carry to be accepted
- DEPTH, 16, FIFO depth in words; power of two, ≥ 8
- STOP_HI, 12, fill level at or above which STOP asserts
- STOP_LO, 8, fill level at or below which STOP releases; STOP_LO < STOP_HI ≤ DEPTH

Ports:
- CLK  in  1  sole clock; serial inputs are synchronous to it
- RST  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous flush: empties FIFO and clears shift register; counters kept
- RX_DATA  in  1  serial data, MSB first
- RX_LOAD  in  1  high during the last (19th) bit of a frame
- DATA  out  16  word at FIFO head
- VALID  out  1  DATA holds a word
- READY  in  1  downstream accepts DATA this cycle
- STOP  out  1  backpressure to transmitter
- OVF  out  1  sticky: an accepted word was lost to a full FIFO
- ADDR_ERR_CNT  out  8  frames dropped for address mismatch, saturating at 255
- state_mon  out  2  {STOP, VALID}

## Operation

- Shift register sr[18:0]: every cycle sr <= {sr[17:0], RX_DATA}. Shifting continues during idle; only the LOAD cycle matters.
- Frame capture: on a cycle with RX_LOAD=1, frame = {sr[17:0], RX_DATA}; addr = frame[18:16], word = frame[15:0].
- addr == MY_ADDR → word issued as write request next cycle; otherwise ADDR_ERR_CNT increments (saturates at 255), nothing written.
- LOAD on consecutive cycles: each cycle is an independent capture (no minimum gap enforced).
- FIFO: first-word-fall-through, DEPTH entries, fill count width log2(DEPTH)+1.
  - Read = VALID & READY.
  - Write accepted if fill < DEPTH, or fill == DEPTH with a read in the same cycle.
  - Write refused → word discarded, OVF set; cleared only by RST.
  - Read and write in the same cycle → fill unchanged.
  - Fill is 0 → VALID=0; DATA holds its last value (don't-care).
- STOP state machine, 2 states:
  - RUN: STOP=0; go to HOLD when fill ≥ STOP_HI.
  - HOLD: STOP=1; go to RUN when fill ≤ STOP_LO.
  - Evaluated on the registered fill count.
- CLR: fill <= 0, read/write pointers <= 0, sr <= 0, pending write cancelled. Takes precedence over a simultaneous write/read.
- Reset mid-frame: partial frame lost; no capture until a new LOAD.

## Timing

- Reset values: DATA=0, VALID=0, STOP=1 (state HOLD), OVF=0, ADDR_ERR_CNT=0, sr=0, fill=0.
- First edge after RST release: fill 0 ≤ STOP_LO → RUN; STOP=0 from the second cycle.
- Latency: LOAD sampled at edge N → write at edge N+1 → VALID=1 and DATA valid after edge N+1.
- Read at edge M → the next word (if any) appears on DATA after edge M; VALID drops after M if fill becomes 0.
- STOP updates one cycle after the fill change that crosses a threshold.
- ADDR_ERR_CNT and OVF update at edge N+1 relative to the LOAD edge N.

## Test plan

- Reset then frame addr=1, word 16'hA5C3, READY=0 → VALID=1 with DATA=A5C3 two edges after LOAD; READY=1 for one cycle → VALID=0, fill=0.
- Frame addr=3, word 16'h1234 → no write, VALID stays 0, ADDR_ERR_CNT=1; send 300 bad frames → counter stuck at 255.
- Back-to-back frames (LOAD every 19 cycles, zero gap), words 0..15, READY=0 → STOP=1 one cycle after the 12th word is written; 16 words stored; 17th word dropped and OVF=1; drain with READY=1 → words 0..15 out in order, STOP=0 one cycle after fill reaches 8.
- Fill=16 with READY=1 on the same edge as a write → write accepted, OVF stays 0, fill stays 16.
- Assert CLR while fill=5 and a LOAD arrives in the same cycle → fill=0, VALID=0, the captured word is discarded; ADDR_ERR_CNT and OVF unchanged.
- Assert RST in mid-frame after 10 bits → all outputs at reset values, STOP=1; release → STOP=0 by the second cycle; next full frame is received correctly.
